// File: rtl/de_pipe_reg_if.sv
// de_pipe_reg_if: D/E pipeline register bus with M-stage hazard info and stall/flush controls
interface de_pipe_reg_if;
  logic        valid_D, valid_E;
  logic [31:0] PC_reg_D, PC_reg_E;
  logic [31:0] rdata1_D, rdata1_E;
  logic [31:0] rdata2_D, rdata2_E;
  logic [31:0] imme_D, imme_E;
  logic [4:0]  Rs1_D, Rs1_E, Rs2_D, Rs2_E, Rd_D, Rd_E;
  logic        RegWrite_D, RegWrite_E, MemRead_D, MemRead_E;
  logic        reg_ren_D, reg_ren_E, auipc_D, auipc_E, ALU_DB_Src_D, ALU_DB_Src_E;
  logic [7:0]  ctrl_D, ctrl_E;
  logic        RegWrite_M, MemRead_M;
  logic [4:0]  Rd_M;
  logic        flush_E, hold_E, stall_D;
  logic [31:0] bubble_cnt;
  modport master (
    output valid_D, PC_reg_D, rdata1_D, rdata2_D, imme_D, Rs1_D, Rs2_D, Rd_D,
           RegWrite_D, MemRead_D, reg_ren_D, auipc_D, ALU_DB_Src_D, ctrl_D,
           RegWrite_M, MemRead_M, Rd_M, flush_E, hold_E,
    input  valid_E, PC_reg_E, rdata1_E, rdata2_E, imme_E, Rs1_E, Rs2_E, Rd_E,
           RegWrite_E, MemRead_E, reg_ren_E, auipc_E, ALU_DB_Src_E, ctrl_E,
           stall_D, bubble_cnt
  );
  modport slave (
    input  valid_D, PC_reg_D, rdata1_D, rdata2_D, imme_D, Rs1_D, Rs2_D, Rd_D,
           RegWrite_D, MemRead_D, reg_ren_D, auipc_D, ALU_DB_Src_D, ctrl_D,
           RegWrite_M, MemRead_M, Rd_M, flush_E, hold_E,
    output valid_E, PC_reg_E, rdata1_E, rdata2_E, imme_E, Rs1_E, Rs2_E, Rd_E,
           RegWrite_E, MemRead_E, reg_ren_E, auipc_E, ALU_DB_Src_E, ctrl_E,
           stall_D, bubble_cnt
  );
endinterface

// File: rtl/de_pipe_reg.sv
// de_pipe_reg: D->E pipeline register with load-use bubble insertion (enabled by LOAD_USE_STALL_EN)
module de_pipe_reg (
  input logic         clk,
  input logic         rst,
  de_pipe_reg_if.slave p
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rdata1, rdata2, imme;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_read, reg_ren, auipc, alu_db_src;
    logic [7:0]  ctrl;
  } e_t;
  e_t          e_q, e_d, ld;
  logic [31:0] cnt_q, cnt_d;
  logic        hazard;
`ifdef LOAD_USE_STALL_EN
  logic use1, use2, load_e, load_m;
  // M forwards only ALU results, so a load still in M is a hazard too
  always_comb begin
    use1   = p.reg_ren_D && p.Rs1_D != 5'd0;
    use2   = p.reg_ren_D && p.ALU_DB_Src_D && p.Rs2_D != 5'd0;
    load_e = e_q.valid && e_q.reg_write && e_q.mem_read;
    load_m = p.RegWrite_M && p.MemRead_M;
    hazard = p.valid_D && (
      (use1 && ((load_e && p.Rs1_D == e_q.rd) || (load_m && p.Rs1_D == p.Rd_M))) ||
      (use2 && ((load_e && p.Rs2_D == e_q.rd) || (load_m && p.Rs2_D == p.Rd_M))));
  end
`else
  logic unused_m;
  assign unused_m = ^{p.RegWrite_M, p.MemRead_M, p.Rd_M};
  assign hazard = 1'b0;
`endif
  always_comb begin
    ld = '{valid: p.valid_D, pc: p.PC_reg_D, rdata1: p.rdata1_D, rdata2: p.rdata2_D,
           imme: p.imme_D, rs1: p.Rs1_D, rs2: p.Rs2_D, rd: p.Rd_D,
           reg_write: p.RegWrite_D && p.valid_D, mem_read: p.MemRead_D && p.valid_D,
           reg_ren: p.reg_ren_D, auipc: p.auipc_D, alu_db_src: p.ALU_DB_Src_D,
           ctrl: p.ctrl_D};
    e_d   = p.hold_E ? e_q : (p.flush_E || hazard) ? '0 : ld;
    cnt_d = (!p.hold_E && !p.flush_E && hazard && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  assign p.stall_D      = p.hold_E || (hazard && !p.flush_E);
  assign p.bubble_cnt   = cnt_q;
  assign p.valid_E      = e_q.valid;
  assign p.PC_reg_E     = e_q.pc;
  assign p.rdata1_E     = e_q.rdata1;
  assign p.rdata2_E     = e_q.rdata2;
  assign p.imme_E       = e_q.imme;
  assign p.Rs1_E        = e_q.rs1;
  assign p.Rs2_E        = e_q.rs2;
  assign p.Rd_E         = e_q.rd;
  assign p.RegWrite_E   = e_q.reg_write;
  assign p.MemRead_E    = e_q.mem_read;
  assign p.reg_ren_E    = e_q.reg_ren;
  assign p.auipc_E      = e_q.auipc;
  assign p.ALU_DB_Src_E = e_q.alu_db_src;
  assign p.ctrl_E       = e_q.ctrl;
endmodule

// File: tb/tb_de_pipe_reg.sv
// tb_de_pipe_reg: scoreboard bench for de_pipe_reg with directed load-use programs and random traffic
module tb_de_pipe_reg;
`ifdef LOAD_USE_STALL_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  typedef struct packed {
    logic        v;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, ren, aui, src;
    logic [7:0]  ctrl;
  } st_t;
  typedef struct packed {
    st_t         e;
    logic [31:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  de_pipe_reg_if bus();
  de_pipe_reg dut (.clk(clk), .rst(rst), .p(bus));
  st_t got;
  assign got = {bus.valid_E, bus.PC_reg_E, bus.rdata1_E, bus.rdata2_E, bus.imme_E,
                bus.Rs1_E, bus.Rs2_E, bus.Rd_E, bus.RegWrite_E, bus.MemRead_E,
                bus.reg_ren_E, bus.auipc_E, bus.ALU_DB_Src_E, bus.ctrl_E};
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  st_t  me, pm, last_d;
  logic [31:0] mcnt;
  // Reference: a load (valid, writes, reads memory) in E or M blocks any consumer of its nonzero rd
  function automatic logic model_haz(st_t d, st_t e, logic mrw, logic mmr, logic [4:0] mrd);
    logic [4:0] srcs [2];
    logic       used [2];
    logic       hit;
    srcs[0] = d.rs1; srcs[1] = d.rs2;
    used[0] = d.ren; used[1] = d.ren && d.src;
    hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (d.v && used[i] && srcs[i] != 5'd0 &&
          ((e.v && e.rw && e.mr && e.rd == srcs[i]) || (mrw && mmr && mrd == srcs[i])))
        hit = 1'b1;
    return EN && hit;
  endfunction
  function automatic st_t rand_d();
    st_t d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d.v   = $urandom_range(0, 9) < 8;
    d.rs1 = 5'($urandom_range(0, 3));
    d.rs2 = 5'($urandom_range(0, 3));
    d.rd  = 5'($urandom_range(0, 3));
    return d;
  endfunction
  function automatic st_t mk(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic rw, logic mr, logic src);
    st_t d;
    d = '0;
    d.v = 1'b1; d.pc = $urandom; d.r1 = $urandom; d.r2 = $urandom; d.imm = $urandom;
    d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.rw = rw; d.mr = mr; d.ren = 1'b1; d.src = src;
    d.ctrl = 8'($urandom);
    return d;
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step(st_t d, logic fl, logic ho, logic mrw, logic mmr, logic [4:0] mrd, output logic stall);
    logic hz;
    @(negedge clk);
    {bus.valid_D, bus.PC_reg_D, bus.rdata1_D, bus.rdata2_D, bus.imme_D, bus.Rs1_D, bus.Rs2_D,
     bus.Rd_D, bus.RegWrite_D, bus.MemRead_D, bus.reg_ren_D, bus.auipc_D, bus.ALU_DB_Src_D,
     bus.ctrl_D} = d;
    bus.flush_E = fl; bus.hold_E = ho;
    bus.RegWrite_M = mrw; bus.MemRead_M = mmr; bus.Rd_M = mrd;
    last_d = d;
    #1;
    hz = model_haz(d, me, mrw, mmr, mrd);
    stall = ho || (hz && !fl);
    chk("stall_D", 32'(bus.stall_D), 32'(stall));
    if (!ho) begin
      if (fl || hz) begin
        if (!fl && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
        me = '0;
      end else begin
        me = d;
        if (!d.v) begin me.rw = 1'b0; me.mr = 1'b0; end
      end
    end
    q.push_back('{e: me, cnt: mcnt});
  endtask
  // Drives a program in order, holding D while stalled; M follows E one cycle later
  task automatic run_prog(st_t prog[$], int stop_after, output int stalls);
    int   idx;
    logic st;
    st_t  eb, d;
    idx = 0; stalls = 0;
    for (int c = 0; c < prog.size() + 4; c++) begin
      if (stop_after > 0 && c == stop_after) break;
      d  = idx < prog.size() ? prog[idx] : '0;
      eb = me;
      step(d, 1'b0, 1'b0, pm.v && pm.rw, pm.v && pm.mr, pm.rd, st);
      pm = eb;
      if (st) stalls++;
      else if (idx < prog.size()) idx++;
    end
  endtask
  task automatic do_reset();
    logic exp_stall;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst valid_E", 32'(bus.valid_E), 32'd0);
    chk("rst bubble_cnt", bus.bubble_cnt, 32'd0);
    exp_stall = bus.hold_E || (model_haz(last_d, '0, bus.RegWrite_M, bus.MemRead_M, bus.Rd_M) && !bus.flush_E);
    chk("rst stall_D", 32'(bus.stall_D), 32'(exp_stall));
    me = '0; mcnt = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if (got !== x.e || bus.bubble_cnt !== x.cnt) begin
          miscompares++;
          $display("FAIL E-stage: got %h cnt %0h expected %h cnt %0h", got, bus.bubble_cnt, x.e, x.cnt);
        end
      end
    end
  end
  initial begin : stim
    st_t  prog[$];
    st_t  lw5, add, nop, d;
    int   stalls;
    logic st;
    me = '0; pm = '0; mcnt = '0; last_d = '0;
    {bus.valid_D, bus.PC_reg_D, bus.rdata1_D, bus.rdata2_D, bus.imme_D, bus.Rs1_D, bus.Rs2_D,
     bus.Rd_D, bus.RegWrite_D, bus.MemRead_D, bus.reg_ren_D, bus.auipc_D, bus.ALU_DB_Src_D,
     bus.ctrl_D} = '0;
    bus.flush_E = 0; bus.hold_E = 0; bus.RegWrite_M = 0; bus.MemRead_M = 0; bus.Rd_M = 0;
    #12;
    chk("reset E-stage", 32'(|got), 32'd0);
    chk("reset bubble_cnt", bus.bubble_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lw5 = mk(5'd5, 5'd2, 5'd0, 1, 1, 0);
    add = mk(5'd6, 5'd5, 5'd7, 1, 0, 1);
    nop = mk(5'd0, 5'd0, 5'd0, 0, 0, 0);
    prog = '{lw5, add};
    run_prog(prog, 0, stalls);
    chk("lw-use stalls", 32'(stalls), EN ? 32'd2 : 32'd0);
    chk("lw-use bubbles", bus.bubble_cnt, EN ? 32'd2 : 32'd0);
    do_reset(); pm = '0;
    prog = '{lw5, nop, mk(5'd6, 5'd5, 5'd1, 1, 0, 1)};
    run_prog(prog, 0, stalls);
    chk("lw-nop-use stalls", 32'(stalls), EN ? 32'd1 : 32'd0);
    chk("lw-nop-use bubbles", bus.bubble_cnt, EN ? 32'd1 : 32'd0);
    do_reset(); pm = '0;
    prog = '{mk(5'd0, 5'd2, 5'd0, 1, 1, 0), mk(5'd6, 5'd0, 5'd0, 1, 0, 1)};
    run_prog(prog, 0, stalls);
    chk("lw x0 stalls", 32'(stalls), 32'd0);
    do_reset(); pm = '0;
    step(lw5, 0, 0, 0, 0, 0, st);
    step(add, 1, 0, 0, 0, 0, st);
    chk("flush+hazard stall", 32'(st), 32'd0);
    @(posedge clk); #1;
    chk("flush bubble valid", 32'(bus.valid_E), 32'd0);
    chk("flush bubble_cnt", bus.bubble_cnt, 32'd0);
    do_reset();
    d = rand_d(); d.v = 1'b1; d.pc = 32'h8000_0010;
    step(d, 0, 0, 0, 0, 0, st);
    for (int i = 0; i < 3; i++) begin
      step(rand_d(), i == 1, 1, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), st);
      chk("hold stall", 32'(st), 32'd1);
    end
    @(posedge clk); #1;
    chk("hold PC_reg_E", bus.PC_reg_E, 32'h8000_0010);
    step(rand_d(), 1, 0, 0, 0, 0, st);
    do_reset(); pm = '0;
    prog = '{lw5, add};
    run_prog(prog, 2, stalls);
    do_reset();
    prog = '{add};
    run_prog(prog, 0, stalls);
    chk("post-reset M stall", 32'(stalls), EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 400; i++)
      step(rand_d(), $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
           1'($urandom), $urandom_range(0, 2) != 0, 5'($urandom_range(0, 3)), st);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/de_pipe_reg.md
DE_PIPE_REG -- requirements
Module: de_pipe_reg

Interface
- REQ-001: clk  in  1  single clock; all state updates on rising edge.
- REQ-002: rst  in  1  asynchronous, active-high reset.
- REQ-003: valid_D / valid_E  in/out  1  instruction present in D / E.
- REQ-004: PC_reg_D / PC_reg_E  in/out  32  instruction PC.
- REQ-005: rdata1_D / rdata1_E  in/out  32  regfile read port 1.
- REQ-006: rdata2_D / rdata2_E  in/out  32  regfile read port 2.
- REQ-007: imme_D / imme_E  in/out  32  decoded immediate.
- REQ-008: Rs1_D / Rs1_E, Rs2_D / Rs2_E, Rd_D / Rd_E  in/out  5 each  register indices.
- REQ-009: RegWrite_D / RegWrite_E, MemRead_D / MemRead_E  in/out  1 each  writeback enable, load.
- REQ-010: reg_ren_D / reg_ren_E, auipc_D / auipc_E, ALU_DB_Src_D / ALU_DB_Src_E  in/out  1 each  EX operand controls.
- REQ-011: ctrl_D / ctrl_E  in/out  8  opaque ALU/memory control, carried unchanged.
- REQ-012: RegWrite_M, MemRead_M  in  1 each;  Rd_M  in  5  M-stage destination info.
- REQ-013: flush_E  in  1  squash the D instruction (taken branch/jump resolved in EX).
- REQ-014: hold_E  in  1  downstream stall; E must not advance.
- REQ-015: stall_D  out  1  hold PC and IF/ID register this cycle.
- REQ-016: bubble_cnt  out  32  count of load-use bubbles inserted.

Function
- REQ-017: The block SHALL compute hazard combinationally: valid_D and some used source (Rs1_D if reg_ren_D; Rs2_D if reg_ren_D and ALU_DB_Src_D) is nonzero and equals either Rd_E (valid_E, RegWrite_E, MemRead_E) or Rd_M (RegWrite_M, MemRead_M).
- REQ-018: The M-stage check SHALL exist because M forwards only ALU results; a load-use pair SHALL therefore incur exactly 2 bubbles, with the consumer entering E while the load is in W.
- REQ-019: stall_D SHALL equal hold_E OR (hazard AND NOT flush_E).
- REQ-020: Next E state priority SHALL be: hold_E (retain all E outputs), then flush_E (bubble), then hazard (bubble, bubble_cnt+1), otherwise load all D fields.
- REQ-021: A bubble SHALL clear valid_E, RegWrite_E and MemRead_E; all other E fields are don't-care but SHALL be zeroed.
- REQ-022: Loading with valid_D=0 SHALL also clear RegWrite_E and MemRead_E.
- REQ-023: During hold_E, flush_E SHALL be ignored; the EX stage keeps flush_E asserted until hold_E deasserts.
- REQ-024: bubble_cnt SHALL saturate at 0xFFFFFFFF and SHALL NOT count flush or hold cycles.
- REQ-025: Latency D to E SHALL be exactly one cycle when no hold, flush or hazard is present.

Reset
- REQ-026: rst SHALL asynchronously clear all E outputs and bubble_cnt to 0; stall_D SHALL then follow REQ-019 with valid_E=0.
- REQ-027: Reset asserted mid-stall SHALL drop the pending bubble sequence; after release the D instruction loads once no M-stage hazard remains.

Configuration
- REQ-028: Macro LOAD_USE_STALL_EN: when defined, hazard SHALL be computed per REQ-017; when undefined, hazard SHALL be constant 0, stall_D SHALL equal hold_E, and bubble_cnt SHALL remain 0.

Verification
- REQ-029: lw x5 then add x6,x5,x7 back to back -> stall_D high 2 cycles, 2 bubbles in E, add enters E when load is in W, bubble_cnt=2.
- REQ-030: lw x5, nop, add x6,x5,x1 -> 1 bubble, bubble_cnt=1; lw x0 then use of x0 -> no stall.
- REQ-031: flush_E=1 with hazard=1 -> E becomes bubble, stall_D=0, bubble_cnt unchanged.
- REQ-032: hold_E=1 for 3 cycles with PC_reg_E=0x80000010 -> E outputs constant, stall_D=1, flush_E pulse ignored until release.
- REQ-033: rst asserted asynchronously between clock edges during the 2-bubble stall -> valid_E=0 and bubble_cnt=0 immediately; with LOAD_USE_STALL_EN undefined, REQ-029 stimulus -> no stall and bubble_cnt=0.
